// File: rtl/fltr_pulse_meas_pkg.sv
// fltr_pulse_meas_pkg: shared types and defaults for the pulse measurement block
package fltr_pulse_meas_pkg;
  localparam int CNT_W_DEF  = 24;
  localparam int DROP_W_DEF = 8;
  typedef logic [7:0]  u8_t;
  typedef logic [31:0] u32_t;
  typedef enum logic [1:0] {ARM, WAIT_RISE, HIGH, LOW} pm_state_t;
  typedef struct packed {
    logic [CNT_W_DEF-1:0] width;
    logic [CNT_W_DEF-1:0] period;
    logic                 ovf;
    logic                 tmo;
  } pm_rec_t;
endpackage

// File: rtl/fltr_edge_det.sv
// fltr_edge_det: registers a level and flags its rising and falling edges
module fltr_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic prev;
  // previous sample of the level, cleared by reset so a high at release reads as a rise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev <= 1'b0;
    else prev <= din;
  assign rise = din & ~prev;
  assign fall = ~din & prev;
endmodule

// File: rtl/fltr_pulse_meas.sv
// fltr_pulse_meas: measures high width and rise-to-rise period of the filtered level; optional idle timeout via FLTR_PULSE_MEAS_TIMEOUT_EN
module fltr_pulse_meas import fltr_pulse_meas_pkg::*; #(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DROP_W  = DROP_W_DEF,
  parameter int TIMEOUT = 1048576
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fltr_out,
  input  logic              en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  m_width,
  output logic [CNT_W-1:0]  m_period,
  output logic              m_ovf,
  output logic              m_tmo,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              busy
);
  localparam logic [CNT_W-1:0] TMO_PERIOD = (TIMEOUT >= 2**CNT_W) ? '1 : CNT_W'(TIMEOUT);
  pm_state_t        state;
  logic [CNT_W-1:0] width_cnt, period_cnt;
  logic             ovf, rise, fall, tmo_hit, cap, load;

  fltr_edge_det u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (fltr_out),
    .rise (rise),
    .fall (fall)
  );

`ifdef FLTR_PULSE_MEAS_TIMEOUT_EN
  logic [31:0] idle_cnt;
  assign tmo_hit = en && state != ARM && !rise && !fall && idle_cnt == 32'(TIMEOUT - 1);
  // idle cycles since the last edge; state changes in measuring states only happen on edges
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idle_cnt <= '0;
    else idle_cnt <= (!en || state == ARM || rise || fall || tmo_hit) ? '0 : idle_cnt + 32'd1;
`else
  assign tmo_hit = 1'b0;
`endif

  assign cap  = en && ((state == LOW && rise) || tmo_hit);
  assign load = cap && (!m_valid || m_ready);
  assign busy = state != ARM;

  // measurement FSM with saturating width/period counters and sticky overflow
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= ARM;
      width_cnt  <= '0;
      period_cnt <= '0;
      ovf        <= 1'b0;
    end else if (!en || tmo_hit) begin
      state      <= ARM;
      width_cnt  <= '0;
      period_cnt <= '0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        ARM: if (!fltr_out) state <= WAIT_RISE;
        WAIT_RISE: if (rise) begin
          state      <= HIGH;
          width_cnt  <= CNT_W'(1);
          period_cnt <= CNT_W'(1);
          ovf        <= 1'b0;
        end
        HIGH: begin
          if (fall) state <= LOW;
          else width_cnt <= (&width_cnt) ? width_cnt : width_cnt + 1'b1;
          period_cnt <= (&period_cnt) ? period_cnt : period_cnt + 1'b1;
          ovf        <= ovf | (&period_cnt) | (!fall & (&width_cnt));
        end
        LOW: if (rise) begin
          state      <= HIGH;
          width_cnt  <= CNT_W'(1);
          period_cnt <= CNT_W'(1);
          ovf        <= 1'b0;
        end else begin
          period_cnt <= (&period_cnt) ? period_cnt : period_cnt + 1'b1;
          ovf        <= ovf | (&period_cnt);
        end
        default: state <= ARM;
      endcase
    end

  // one-entry holding register; a capture blocked by a stalled record is counted as dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_width  <= '0;
      m_period <= '0;
      m_ovf    <= 1'b0;
      m_tmo    <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (load) begin
        m_valid  <= 1'b1;
        m_width  <= width_cnt;
        m_period <= tmo_hit ? TMO_PERIOD : period_cnt;
        m_ovf    <= ovf;
        m_tmo    <= tmo_hit;
      end else if (m_valid && m_ready) m_valid <= 1'b0;
      if (cap && !load && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
    end
endmodule

// File: tb/tb_fltr_pulse_meas.sv
// tb_fltr_pulse_meas: directed checks of pulse measurement, backpressure, saturation, enable and timeout
module tb_fltr_pulse_meas;
  import fltr_pulse_meas_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, fltr_out = 1'b0, en = 1'b0, m_ready = 1'b0;
  logic m_valid, m_ovf, m_tmo, busy;
  logic [23:0] m_width, m_period;
  u8_t drop_cnt;
  logic s_valid, s_ovf, s_tmo, s_busy;
  logic [3:0] s_width, s_period;
  u8_t s_drop;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  fltr_pulse_meas #(.CNT_W(24), .DROP_W(8), .TIMEOUT(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .fltr_out(fltr_out), .en(en),
    .m_valid(m_valid), .m_ready(m_ready), .m_width(m_width), .m_period(m_period),
    .m_ovf(m_ovf), .m_tmo(m_tmo), .drop_cnt(drop_cnt), .busy(busy)
  );

  fltr_pulse_meas #(.CNT_W(4), .DROP_W(8)) u_small (
    .clk(clk), .rst_n(rst_n), .fltr_out(fltr_out), .en(en),
    .m_valid(s_valid), .m_ready(m_ready), .m_width(s_width), .m_period(s_period),
    .m_ovf(s_ovf), .m_tmo(s_tmo), .drop_cnt(s_drop), .busy(s_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic level(input logic v, input int n);
    fltr_out = v;
    repeat (n) tick();
  endtask

  task automatic do_reset(input logic v);
    rst_n = 1'b0;
    fltr_out = v;
    en = 1'b1;
    m_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fltr_out = 1'b0;
    en = 1'b1;
    m_ready = 1'b1;
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    checks++; if ({m_width, m_period} !== 48'd0) begin errors++; $display("FAIL reset_data: got %0d/%0d want 0/0", m_width, m_period); end
    checks++; if ({m_ovf, m_tmo, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {m_ovf, m_tmo, busy}); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_pulse_train();
    do_reset(1'b0);
    level(0, 2);
    level(1, 3);
    level(0, 5);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL train_no_early: got %b want 0", m_valid); end
    level(1, 1);
    checks++; if ({m_valid, m_width, m_period, m_ovf} !== {1'b1, 24'd3, 24'd8, 1'b0}) begin errors++; $display("FAIL train_rec1: got v=%b w=%0d p=%0d o=%b want v=1 w=3 p=8 o=0", m_valid, m_width, m_period, m_ovf); end
    level(1, 2);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL train_consumed: got %b want 0", m_valid); end
    level(0, 5);
    level(1, 1);
    checks++; if ({m_valid, m_width, m_period} !== {1'b1, 24'd3, 24'd8}) begin errors++; $display("FAIL train_rec2: got v=%b w=%0d p=%0d want v=1 w=3 p=8", m_valid, m_width, m_period); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL train_busy: got %b want 1", busy); end
  endtask

  task automatic test_high_at_reset();
    do_reset(1'b1);
    level(1, 4);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hi_rst_armed: got busy=%b want 0", busy); end
    level(0, 2);
    level(1, 2);
    level(0, 2);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL hi_rst_no_rec: got %b want 0", m_valid); end
    level(1, 1);
    checks++; if ({m_valid, m_width, m_period} !== {1'b1, 24'd2, 24'd4}) begin errors++; $display("FAIL hi_rst_rec: got v=%b w=%0d p=%0d want v=1 w=2 p=4", m_valid, m_width, m_period); end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0);
    m_ready = 1'b0;
    level(0, 2);
    level(1, 3);
    level(0, 5);
    level(1, 1);
    level(1, 1);
    level(0, 4);
    level(1, 1);
    level(1, 1);
    level(0, 4);
    level(1, 1);
    checks++; if ({m_valid, m_width, m_period} !== {1'b1, 24'd3, 24'd8}) begin errors++; $display("FAIL bp_held: got v=%b w=%0d p=%0d want v=1 w=3 p=8", m_valid, m_width, m_period); end
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL bp_drops: got %0d want 2", drop_cnt); end
    level(1, 3);
    level(0, 3);
    m_ready = 1'b1;
    level(1, 1);
    checks++; if ({m_valid, m_width, m_period} !== {1'b1, 24'd4, 24'd7}) begin errors++; $display("FAIL bp_swap: got v=%b w=%0d p=%0d want v=1 w=4 p=7", m_valid, m_width, m_period); end
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL bp_swap_drop: got %0d want 2", drop_cnt); end
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", m_valid); end
    m_ready = 1'b0;
    level(0, 2);
    level(1, 1);
    rst_n = 1'b0;
    #1;
    checks++; if ({m_valid, drop_cnt, busy} !== {1'b0, 8'd0, 1'b0}) begin errors++; $display("FAIL mid_reset: got v=%b d=%0d b=%b want 0/0/0", m_valid, drop_cnt, busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset(1'b0);
    level(0, 2);
    level(1, 20);
    level(0, 3);
    level(1, 1);
    checks++; if ({s_valid, s_width, s_period, s_ovf} !== {1'b1, 4'd15, 4'd15, 1'b1}) begin errors++; $display("FAIL sat_rec: got v=%b w=%0d p=%0d o=%b want v=1 w=15 p=15 o=1", s_valid, s_width, s_period, s_ovf); end
    level(1, 1);
    level(0, 2);
    level(1, 1);
    checks++; if ({s_valid, s_width, s_period, s_ovf} !== {1'b1, 4'd2, 4'd4, 1'b0}) begin errors++; $display("FAIL sat_next: got v=%b w=%0d p=%0d o=%b want v=1 w=2 p=4 o=0", s_valid, s_width, s_period, s_ovf); end
  endtask

  task automatic test_enable();
    do_reset(1'b0);
    m_ready = 1'b0;
    level(0, 2);
    level(1, 3);
    level(0, 5);
    level(1, 1);
    level(1, 1);
    en = 1'b0;
    tick();
    checks++; if ({busy, m_valid, m_width} !== {1'b0, 1'b1, 24'd3}) begin errors++; $display("FAIL en_off: got b=%b v=%b w=%0d want b=0 v=1 w=3", busy, m_valid, m_width); end
    m_ready = 1'b1;
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL en_accept: got %b want 0", m_valid); end
    en = 1'b1;
    level(1, 3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_wait_low: got %b want 0", busy); end
    level(0, 1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL en_armed: got %b want 1", busy); end
    level(1, 2);
    level(0, 2);
    level(1, 1);
    checks++; if ({m_valid, m_width, m_period, drop_cnt} !== {1'b1, 24'd2, 24'd4, 8'd0}) begin errors++; $display("FAIL en_rec: got v=%b w=%0d p=%0d d=%0d want v=1 w=2 p=4 d=0", m_valid, m_width, m_period, drop_cnt); end
  endtask

  task automatic test_timeout();
    do_reset(1'b0);
    level(0, 2);
    level(1, 2);
`ifdef FLTR_PULSE_MEAS_TIMEOUT_EN
    level(0, 16);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b want 0", m_valid); end
    level(0, 1);
    checks++; if ({m_valid, m_tmo, m_width, m_period, busy} !== {1'b1, 1'b1, 24'd2, 24'd16, 1'b0}) begin errors++; $display("FAIL tmo_rec: got v=%b t=%b w=%0d p=%0d b=%b want v=1 t=1 w=2 p=16 b=0", m_valid, m_tmo, m_width, m_period, busy); end
`else
    level(0, 40);
    checks++; if ({m_valid, m_tmo, busy} !== 3'b001) begin errors++; $display("FAIL no_tmo: got v=%b t=%b b=%b want v=0 t=0 b=1", m_valid, m_tmo, busy); end
`endif
  endtask

  initial begin
    test_reset();
    test_pulse_train();
    test_high_at_reset();
    test_back_to_back();
    test_saturation();
    test_enable();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
